instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Sequential instruction fetcher in front of a fixed 1-cycle-latency
//   instruction memory. It issues word-aligned reads, catches the returned
//   word one cycle later and queues {instruction, pc} pairs in a 2-entry
//   FIFO towards the decode stage. Reads are only issued when the FIFO is
//   guaranteed to have room for the returning data (credit rule), so the
//   FIFO can never overflow. A redirect flushes everything (queued and
//   in-flight) and restarts fetching at the aligned redirect target.
//
// Parameters:
//   ADDR_WIDTH       width of all byte addresses
//   RESET_PC         first fetch byte address after reset (bits [1:0] ignored)
//
// Ports:
//   clock            single clock, rising-edge active
//   reset            synchronous active-high reset, overrides everything
//   redirect         branch/jump/trap redirect request
//   redirect_addr    byte address to fetch from after a redirect
//   imem_read        read strobe to instruction memory
//   imem_addr        word-aligned byte address of the read
//   imem_instruction read data, valid the cycle after imem_read
//   out_valid        fetched instruction available (FIFO not empty)
//   out_ready        decode stage accepts the output this cycle
//   out_instruction  fetched instruction word (FIFO head)
//   out_pc           byte address of out_instruction (FIFO head)
// ---------------------------------------------------------------------------

// Property checker for the fetch unit; holds no state of its own.
module instruction_fetch_unit_checker #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input logic                  clock,
    input logic                  reset,
    input logic                  redirect,
    input logic                  out_valid,
    input logic                  out_ready,
    input logic [1:0]            count,
    input logic [ADDR_WIDTH-1:0] imem_addr,
    input logic [ADDR_WIDTH-1:0] out_pc,
    input logic [31:0]           out_instruction
);

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        count <= 2'd2);

    a_addr_aligned: assert property (@(posedge clock) disable iff (reset)
        imem_addr[1:0] == 2'b00);

    a_hold_stable: assert property (@(posedge clock) disable iff (reset)
        (out_valid && !out_ready && !redirect) |=>
        (out_valid && $stable(out_pc) && $stable(out_instruction)));

endmodule

module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  imem_read,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(32'd4);

    // Architectural state
    logic [ADDR_WIDTH-1:0] fetch_pc_q,     fetch_pc_d;
    logic                  in_flight_q,    in_flight_d;
    logic [ADDR_WIDTH-1:0] in_flight_pc_q, in_flight_pc_d;
    logic [1:0]            count_q,        count_d;
    // FIFO kept as head/tail registers; the head always drives the output
    logic [31:0]           head_instr_q,   head_instr_d;
    logic [ADDR_WIDTH-1:0] head_pc_q,      head_pc_d;
    logic [31:0]           tail_instr_q,   tail_instr_d;
    logic [ADDR_WIDTH-1:0] tail_pc_q,      tail_pc_d;

    // Combinational helpers
    logic                  out_valid_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic [2:0]            occupancy_s;

    // Handshake, credit and issue decisions for the current cycle.
    always_comb begin
        out_valid_s = (count_q != 2'd0);
        // out_ready is meaningless while nothing is presented
        pop_s       = out_valid_s && out_ready;
        // Returning data always lands the cycle after its read unless flushed
        push_s      = in_flight_q && !redirect;
        // Entries that will occupy the FIFO once the in-flight word lands.
        // pop only happens with count >= 1, so this never underflows.
        occupancy_s = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, pop_s};
        if (!reset && !redirect && (occupancy_s <= 3'd1)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Fetch pointer and in-flight tracking.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        in_flight_pc_d = in_flight_pc_q;
        in_flight_d    = in_flight_q;
        if (redirect) begin
            fetch_pc_d  = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
            in_flight_d = 1'b0;
        end else if (issue_s) begin
            in_flight_d    = 1'b1;
            in_flight_pc_d = fetch_pc_q;
            // Natural modulo-2^ADDR_WIDTH wrap of the adder
            fetch_pc_d     = fetch_pc_q + PC_STEP;
        end else begin
            // Any outstanding word lands this cycle, so nothing remains in flight
            in_flight_d = 1'b0;
        end
    end

    // FIFO push/pop with order preservation; redirect flushes it.
    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        if (redirect) begin
            count_d = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd0) begin
                        head_instr_d = imem_instruction;
                        head_pc_d    = in_flight_pc_q;
                    end else begin
                        tail_instr_d = imem_instruction;
                        tail_pc_d    = in_flight_pc_q;
                    end
                end
                2'b01: begin
                    count_d      = count_q - 2'd1;
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                end
                2'b11: begin
                    // Count is unchanged; the new word goes behind whatever remains
                    if (count_q == 2'd1) begin
                        head_instr_d = imem_instruction;
                        head_pc_d    = in_flight_pc_q;
                    end else begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        tail_instr_d = imem_instruction;
                        tail_pc_d    = in_flight_pc_q;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // State registers; reset overrides redirect and every other input.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q     <= RESET_PC_AL;
            in_flight_q    <= 1'b0;
            in_flight_pc_q <= {ADDR_WIDTH{1'b0}};
            count_q        <= 2'd0;
            head_instr_q   <= 32'h0000_0000;
            head_pc_q      <= {ADDR_WIDTH{1'b0}};
            tail_instr_q   <= 32'h0000_0000;
            tail_pc_q      <= {ADDR_WIDTH{1'b0}};
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            in_flight_q    <= in_flight_d;
            in_flight_pc_q <= in_flight_pc_d;
            count_q        <= count_d;
            head_instr_q   <= head_instr_d;
            head_pc_q      <= head_pc_d;
            tail_instr_q   <= tail_instr_d;
            tail_pc_q      <= tail_pc_d;
        end
    end

    // The read strobe must react within the cycle to redirect and pop,
    // so it is decoded from state plus inputs; data outputs come from flops.
    assign imem_read       = issue_s;
    assign imem_addr       = fetch_pc_q;
    assign out_valid       = out_valid_s;
    assign out_instruction = head_instr_q;
    assign out_pc          = head_pc_q;

    instruction_fetch_unit_checker #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_checker (
        .clock           (clock),
        .reset           (reset),
        .redirect        (redirect),
        .out_valid       (out_valid_s),
        .out_ready       (out_ready),
        .count           (count_q),
        .imem_addr       (fetch_pc_q),
        .out_pc          (head_pc_q),
        .out_instruction (head_instr_q)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. Directed scenarios plus a random
// out_ready phase; a scoreboard queue holds the expected {pc, instruction}
// stream and a negedge monitor pops it on every accepted output.
module tb_instruction_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = 32'h0000_0000;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction = 32'h0000_0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;

    // Second instance exercising the address wrap from a high RESET_PC
    logic        w_redirect = 1'b0;
    logic [31:0] w_redirect_addr = 32'h0000_0000;
    logic        w_imem_read;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_instruction = 32'h0000_0000;
    logic        w_out_valid;
    logic        w_out_ready = 1'b1;
    logic [31:0] w_out_instruction;
    logic [31:0] w_out_pc;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_accept = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_pc   = 32'h0000_0000;
    logic [31:0] hold_instr = 32'h0000_0000;

    instruction_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .redirect(redirect), .redirect_addr(redirect_addr),
        .imem_read(imem_read), .imem_addr(imem_addr), .imem_instruction(imem_instruction),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc(out_pc)
    );

    instruction_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clock(clock), .reset(reset), .redirect(w_redirect), .redirect_addr(w_redirect_addr),
        .imem_read(w_imem_read), .imem_addr(w_imem_addr), .imem_instruction(w_imem_instruction),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instruction(w_out_instruction), .out_pc(w_out_pc)
    );

    always #5 clock = ~clock;

    // Memory contents: word i holds 32'h1000_0000 + i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    // One-cycle-latency instruction memories
    always @(posedge clock) begin
        if (imem_read)   imem_instruction   <= mem_word(imem_addr);
        if (w_imem_read) w_imem_instruction <= mem_word(w_imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        e.instr = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        redirect = 1'b0;
        exp_q.delete();
        repeat (n) step();
        reset = 1'b0;
    endtask

    // Scoreboard monitor: flushed outputs (reset/redirect cycles) are not deliveries
    always @(negedge clock) begin
        if (hold_prev) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_pc", out_pc, hold_pc);
            chk("hold_instr", out_instruction, hold_instr);
        end
        if (!reset && !redirect && out_valid && out_ready) begin
            n_accept++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got pc %h expected no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_pc", out_pc, mon_e.pc);
                chk("sb_instr", out_instruction, mon_e.instr);
            end
        end
        hold_prev  = !reset && !redirect && out_valid && !out_ready;
        hold_pc    = out_pc;
        hold_instr = out_instruction;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wrap_pcs [3];
        logic [31:0] redir_tgts [5];
        logic [31:0] next_pc;
        int          acc_start;
        int          r;
        wrap_pcs   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        redir_tgts = '{32'h0000_2001, 32'h0000_0FFE, 32'hFFFF_FFF4, 32'h0000_8000, 32'h0000_0406};

        // ---------------- reset state + S1: streaming with out_ready=1
        out_ready = 1'b1;
        repeat (3) step();
        chk("rst_imem_read", {31'd0, imem_read}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0;                                    // cycle 0
        for (int k = 0; k < 4; k++) push_exp(32'(k * 4));
        #1;
        chk("s1_c0_read", {31'd0, imem_read}, 32'd1);
        chk("s1_c0_addr", imem_addr, 32'h0000_0000);
        step();                                          // cycle 1
        chk("s1_c1_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();                                      // cycles 2..5
            chk("s1_valid", {31'd0, out_valid}, 32'd1);
            chk("s1_pc", out_pc, 32'(k * 4));
            if (k < 3) begin
                chk("wrap_valid", {31'd0, w_out_valid}, 32'd1);
                chk("wrap_pc", w_out_pc, wrap_pcs[k]);
                chk("wrap_instr", w_out_instruction, mem_word(wrap_pcs[k]));
            end
        end
        step();
        out_ready = 1'b0;

        // ---------------- S2: stall 5 cycles after first valid
        do_reset(2);                                     // cycle 0
        push_exp(32'h0000_0000);
        push_exp(32'h0000_0004);
        push_exp(32'h0000_0008);
        step();
        step();                                          // cycle 2
        chk("s2_first_valid", {31'd0, out_valid}, 32'd1);
        chk("s2_first_pc", out_pc, 32'h0000_0000);
        step();
        for (int k = 0; k < 3; k++) begin
            step();                                      // cycles 4..6
            chk("s2_stall_read", {31'd0, imem_read}, 32'd0);
            chk("s2_stall_pc", out_pc, 32'h0000_0000);
        end
        step();                                          // cycle 7
        out_ready = 1'b1;
        #1;
        chk("s2_release_read", {31'd0, imem_read}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();                           // cycles 7..9
            chk("s2_drain_valid", {31'd0, out_valid}, 32'd1);
            chk("s2_drain_pc", out_pc, 32'(k * 4));
        end
        step();
        out_ready = 1'b0;

        // ---------------- S3: redirect with FIFO occupied and a read in flight
        do_reset(2);                                     // cycle 0
        step();
        step();                                          // cycle 2
        redirect = 1'b1;
        redirect_addr = 32'h0000_0103;
        #1;
        chk("s3_redir_read", {31'd0, imem_read}, 32'd0);
        step();                                          // cycle 3
        redirect = 1'b0;
        push_exp(32'h0000_0100);
        push_exp(32'h0000_0104);
        push_exp(32'h0000_0108);
        out_ready = 1'b1;
        #1;
        chk("s3_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("s3_target_read", {31'd0, imem_read}, 32'd1);
        chk("s3_target_addr", imem_addr, 32'h0000_0100);
        step();                                          // cycle 4
        chk("s3_c4_valid", {31'd0, out_valid}, 32'd0);
        step();                                          // cycle 5
        chk("s3_first_valid", {31'd0, out_valid}, 32'd1);
        chk("s3_first_pc", out_pc, 32'h0000_0100);
        step();
        step();
        step();
        out_ready = 1'b0;

        // ---------------- S4: reset during a full stall
        do_reset(2);
        step();
        step();
        step();                                          // cycle 3, count 2
        chk("s4_full_valid", {31'd0, out_valid}, 32'd1);
        chk("s4_full_read", {31'd0, imem_read}, 32'd0);
        step();
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("s4_rst_read", {31'd0, imem_read}, 32'd0);
        step();
        chk("s4_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("s4_rst_read2", {31'd0, imem_read}, 32'd0);
        reset = 1'b0;
        push_exp(32'h0000_0000);
        push_exp(32'h0000_0004);
        out_ready = 1'b1;
        #1;
        chk("s4_restart_read", {31'd0, imem_read}, 32'd1);
        chk("s4_restart_addr", imem_addr, 32'h0000_0000);
        step();
        step();
        step();
        step();
        out_ready = 1'b0;

        // ---------------- S5: random out_ready with occasional redirects
        do_reset(2);
        next_pc = 32'h0000_0000;
        acc_start = n_accept;
        r = 0;
        for (int i = 0; i < 1000; i++) begin
            if ((i % 200) == 150) begin
                redirect = 1'b1;
                redirect_addr = redir_tgts[r];
                exp_q.delete();
                next_pc = redir_tgts[r] & 32'hFFFF_FFFC;
                r++;
            end else begin
                redirect = 1'b0;
            end
            while (exp_q.size() < 4) begin
                push_exp(next_pc);
                next_pc = next_pc + 32'd4;
            end
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        redirect = 1'b0;
        out_ready = 1'b0;
        step();
        chk("rand_progress", {31'd0, (n_accept - acc_start) > 200}, 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
